pipelined_addsub: RTL and testbench

Parametrised, pipelined two's-complement adder/subtractor. It is the multi-bit successor of the team's 1-bit AdderSubtractor cell and keeps the same operand convention: result = A + (B XOR op) + cin. The carry chain is split into CHUNK-bit segments, with one register stage per segment. A valid/ready handshake runs on both sides, and the block reports carry, signed overflow, zero and negative flags. It sits in the IEEE_ALU datapath and feeds mantissa/exponent arithmetic.

---
 rtl/pipelined_addsub.sv | 122 ++++++++++++
 tb/tb_pipelined_addsub.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipelined_addsub.sv
// Pipelined two's-complement adder/subtractor: result = a + (b ^ {WIDTH{op}}) + cin,
// carry chain cut into CHUNK-bit segments with one register stage per segment.
module pipelined_addsub #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             op,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             ovf,
  output logic             zero,
  output logic             neg
);

  localparam int STAGES = WIDTH / CHUNK;

  // Handshake: a transfer happens on a rising edge where valid && ready. The whole
  // pipeline advances together when the output slot is empty or being drained, so
  // in_ready is that same advance term (combinational from out_ready).
  logic adv;

  // Per-stage state: valid bit, operand skew (a and inverted-or-not b), partial
  // result with chunks [0..k] filled in, and the carry out of chunk k.
  logic [STAGES-1:0] v_q;
  logic [STAGES-1:0] c_q;
  logic [WIDTH-1:0]  a_q  [STAGES];
  logic [WIDTH-1:0]  bx_q [STAGES];
  logic [WIDTH-1:0]  r_q  [STAGES];
  logic              ovf_q;
  logic              zero_q;
  logic              neg_q;

  // Stage inputs: stage 0 reads the ports, stage k reads stage k-1's registers.
  logic [STAGES-1:0] si_c;
  logic [STAGES-1:0] v_d;
  logic [STAGES-1:0] c_d;
  logic [WIDTH-1:0]  si_a  [STAGES];
  logic [WIDTH-1:0]  si_bx [STAGES];
  logic [WIDTH-1:0]  si_r  [STAGES];
  logic [WIDTH-1:0]  r_d   [STAGES];
  logic [CHUNK:0]    sum;
  logic [WIDTH-1:0]  fres;
  logic              ovf_d;
  logic              zero_d;
  logic              neg_d;

  assign adv      = out_ready || !v_q[STAGES-1];
  assign in_ready = adv;

  always_comb begin
    si_a[0]  = a;
    si_bx[0] = b ^ {WIDTH{op}};
    si_r[0]  = '0;
    si_c[0]  = cin;
    v_d[0]   = in_valid;
    for (int k = 1; k < STAGES; k++) begin
      si_a[k]  = a_q[k-1];
      si_bx[k] = bx_q[k-1];
      si_r[k]  = r_q[k-1];
      si_c[k]  = c_q[k-1];
      v_d[k]   = v_q[k-1];
    end
    sum = '0;
    c_d = '0;
    for (int k = 0; k < STAGES; k++) begin
      sum = {1'b0, si_a[k][k*CHUNK +: CHUNK]} + {1'b0, si_bx[k][k*CHUNK +: CHUNK]}
          + {{CHUNK{1'b0}}, si_c[k]};
      r_d[k] = si_r[k];
      r_d[k][k*CHUNK +: CHUNK] = sum[CHUNK-1:0];
      c_d[k] = sum[CHUNK];
    end
    // Flags come from the completed word entering the final register.
    fres   = r_d[STAGES-1];
    ovf_d  = (si_a[STAGES-1][WIDTH-1] == si_bx[STAGES-1][WIDTH-1])
          && (fres[WIDTH-1] != si_a[STAGES-1][WIDTH-1]);
    zero_d = (fres == '0);
    neg_d  = fres[WIDTH-1];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_q    <= '0;
      c_q    <= '0;
      ovf_q  <= 1'b0;
      zero_q <= 1'b0;
      neg_q  <= 1'b0;
      for (int k = 0; k < STAGES; k++) begin
        a_q[k]  <= '0;
        bx_q[k] <= '0;
        r_q[k]  <= '0;
      end
    end else if (adv) begin
      v_q    <= v_d;
      c_q    <= c_d;
      ovf_q  <= ovf_d;
      zero_q <= zero_d;
      neg_q  <= neg_d;
      for (int k = 0; k < STAGES; k++) begin
        a_q[k]  <= si_a[k];
        bx_q[k] <= si_bx[k];
        r_q[k]  <= r_d[k];
      end
    end
  end

  assign out_valid = v_q[STAGES-1];
  assign result    = r_q[STAGES-1];
  assign cout      = c_q[STAGES-1];
  assign ovf       = ovf_q;
  assign zero      = zero_q;
  assign neg       = neg_q;

endmodule

// File: tb/tb_pipelined_addsub.sv
// Bench for pipelined_addsub: directed cases on a 32/8 instance plus random sweeps
// on 32/8, 8/8, 12/4 and 64/16 against a signed/unsigned arithmetic model.
module tb_pipelined_addsub;

  localparam int NCFG = 4;

  function automatic int cfg_w(input int g);
    case (g)
      0:       return 32;
      1:       return 8;
      2:       return 12;
      default: return 64;
    endcase
  endfunction

  function automatic int cfg_c(input int g);
    case (g)
      0:       return 8;
      1:       return 8;
      2:       return 4;
      default: return 16;
    endcase
  endfunction

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [63:0] a_bus, b_bus;
  logic        op_s, cin_s;
  logic        iv   [NCFG];
  logic        ordy [NCFG];
  logic        irdy [NCFG];
  logic        ovld [NCFG];
  logic        co   [NCFG];
  logic        ov   [NCFG];
  logic        zr   [NCFG];
  logic        ng   [NCFG];
  logic [63:0] res  [NCFG];

  for (genvar g = 0; g < NCFG; g++) begin : g_dut
    localparam int W = cfg_w(g);
    localparam int C = cfg_c(g);
    logic [W-1:0] r;
    pipelined_addsub #(.WIDTH(W), .CHUNK(C)) u_dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(iv[g]), .in_ready(irdy[g]),
      .a(a_bus[W-1:0]), .b(b_bus[W-1:0]), .op(op_s), .cin(cin_s),
      .out_valid(ovld[g]), .out_ready(ordy[g]),
      .result(r), .cout(co[g]), .ovf(ov[g]), .zero(zr[g]), .neg(ng[g])
    );
    assign res[g] = 64'(r);
  end

  // scoreboard state: expected record = {result[63:0], cout, ovf, zero, neg}
  logic [67:0] exp_q [$];
  int          acc_q [$];
  int          stl_q [$];
  int          errors = 0;
  int          checks = 0;
  int          cyc = 0;
  int          stall_cnt = 0;
  int          pops = 0;
  int          cur_lat = 0;
  int          last_lat = 0;
  bit          seen = 0;
  bit          accepted = 0;
  logic [67:0] last_obs = '0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
    end
  endtask

  // Reference: plain unsigned sum for result/carry, true signed sum for overflow.
  function automatic logic [67:0] model(input int g, input logic [63:0] av, input logic [63:0] bv,
                                        input logic opv, input logic cv);
    int               w;
    logic [63:0]      mask, am, bm, r;
    logic [64:0]      full;
    logic signed [66:0] sa, sb, ss, lim;
    logic             c_o, o_v, z_r, n_g;
    w    = cfg_w(g);
    mask = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
    am   = av & mask;
    bm   = (opv ? ~bv : bv) & mask;
    full = 65'(am) + 65'(bm) + 65'(cv);
    r    = full[63:0] & mask;
    c_o  = full[w];
    sa   = 67'(am);
    if (am[w-1]) sa = sa - (67'sd1 <<< w);
    sb   = 67'(bm);
    if (bm[w-1]) sb = sb - (67'sd1 <<< w);
    ss   = sa + sb + (cv ? 67'sd1 : 67'sd0);
    lim  = 67'sd1 <<< (w - 1);
    o_v  = (ss >= lim) || (ss < -lim);
    z_r  = (r == 64'd0);
    n_g  = r[w-1];
    return {r, c_o, o_v, z_r, n_g};
  endfunction

  // driver tasks
  task automatic drive(input int g, input logic v, input logic [63:0] av, input logic [63:0] bv,
                       input logic opv, input logic cv, input logic rdy);
    iv[g]   = v;
    a_bus   = av;
    b_bus   = bv;
    op_s    = opv;
    cin_s   = cv;
    ordy[g] = rdy;
  endtask

  // Called at a falling edge with inputs driven; checks this cycle, ends at next falling edge.
  task automatic cycle(input int g);
    logic [67:0] obs;
    int stg;
    stg = cfg_w(g) / cfg_c(g);
    #1;
    chk("in_ready_rule", 64'(irdy[g]), 64'(ordy[g] || !ovld[g]));
    accepted = iv[g] && irdy[g];
    if (accepted) begin
      exp_q.push_back(model(g, a_bus, b_bus, op_s, cin_s));
      acc_q.push_back(cyc);
      stl_q.push_back(stall_cnt);
    end
    if (ovld[g]) begin
      obs = {res[g], co[g], ov[g], zr[g], ng[g]};
      if (exp_q.size() == 0) begin
        chk("spurious_out_valid", 64'(ovld[g]), 64'd0);
      end else begin
        chk("result", obs[67:4], exp_q[0][67:4]);
        chk("flags", 64'(obs[3:0]), 64'(exp_q[0][3:0]));
        if (!seen) begin
          cur_lat = cyc - acc_q[0];
          chk("latency", 64'(cur_lat), 64'(stg + stall_cnt - stl_q[0]));
          seen = 1;
        end
        if (ordy[g]) begin
          last_obs = obs;
          last_lat = cur_lat;
          void'(exp_q.pop_front());
          void'(acc_q.pop_front());
          void'(stl_q.pop_front());
          seen = 0;
          pops++;
        end
      end
    end
    if (ovld[g] && !ordy[g]) stall_cnt++;
    cyc++;
    @(negedge clk);
  endtask

  task automatic send(input int g, input logic [63:0] av, input logic [63:0] bv,
                      input logic opv, input logic cv);
    int n;
    n = 0;
    do begin
      drive(g, 1'b1, av, bv, opv, cv, 1'b1);
      cycle(g);
      n++;
    end while (!accepted && n < 50);
    chk("send_accepted", 64'(accepted), 64'd1);
    iv[g] = 1'b0;
  endtask

  task automatic drain(input int g);
    for (int n = 0; n < 200 && exp_q.size() > 0; n++) begin
      drive(g, 1'b0, a_bus, b_bus, op_s, cin_s, 1'b1);
      cycle(g);
    end
    chk("drain_empty", 64'(exp_q.size()), 64'd0);
  endtask

  task automatic check_last(input string tag, input logic [63:0] r, input logic [3:0] f);
    chk({tag, "_result"}, last_obs[67:4], r);
    chk({tag, "_flags"}, 64'(last_obs[3:0]), 64'(f));
    chk({tag, "_latency"}, 64'(last_lat), 64'd4);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int          i, p0, n_acc;
    bit          pend;
    logic [63:0] ra, rb;
    logic        rop, rcin;

    for (int g = 0; g < NCFG; g++) begin
      iv[g]   = 1'b0;
      ordy[g] = 1'b1;
    end
    a_bus = '0; b_bus = '0; op_s = 1'b0; cin_s = 1'b0;

    // reset state
    #12;
    chk("rst_out_valid", 64'(ovld[0]), 64'd0);
    chk("rst_result", res[0], 64'd0);
    chk("rst_flags", 64'({co[0], ov[0], zr[0], ng[0]}), 64'd0);
    chk("rst_in_ready", 64'(irdy[0]), 64'd1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // carry out of all-ones + 1
    send(0, 64'hFFFF_FFFF, 64'd1, 1'b0, 1'b0);
    drain(0);
    check_last("wrap", 64'h0, 4'b1010);

    // subtraction with borrow, then op=1 cin=0
    send(0, 64'd5, 64'd7, 1'b1, 1'b1);
    drain(0);
    check_last("sub_borrow", 64'hFFFF_FFFE, 4'b0001);
    send(0, 64'd5, 64'd7, 1'b1, 1'b0);
    drain(0);
    check_last("sub_nocin", 64'hFFFF_FFFD, 4'b0001);

    // signed overflow both directions
    send(0, 64'h7FFF_FFFF, 64'd1, 1'b0, 1'b0);
    drain(0);
    check_last("ovf_pos", 64'h8000_0000, 4'b0101);
    send(0, 64'h8000_0000, 64'd1, 1'b1, 1'b1);
    drain(0);
    check_last("ovf_neg", 64'h7FFF_FFFF, 4'b1100);

    // back-to-back stream with a three-cycle downstream stall
    i = 0;
    p0 = pops;
    for (int c = 0; c < 80 && (i < 10 || exp_q.size() > 0); c++) begin
      drive(0, i < 10, 64'(i), 64'(3 * i), 1'b0, 1'b0, !(c >= 6 && c <= 8));
      if (c >= 6 && c <= 8) begin
        #1;
        chk("stall_in_ready", 64'(irdy[0]), 64'd0);
        chk("stall_hold", res[0], 64'd8);
      end
      cycle(0);
      if (accepted) i++;
    end
    chk("stream_count", 64'(pops - p0), 64'd10);
    chk("stream_last", last_obs[67:4], 64'd36);

    // reset with three transfers in flight
    for (int k = 0; k < 3; k++) begin
      drive(0, 1'b1, 64'(100 + k), 64'd1, 1'b0, 1'b0, 1'b1);
      cycle(0);
    end
    drive(0, 1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
    cycle(0);
    #1;
    chk("pre_reset_valid", 64'(ovld[0]), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", 64'(ovld[0]), 64'd0);
    chk("mid_rst_result", res[0], 64'd0);
    chk("mid_rst_flags", 64'({co[0], ov[0], zr[0], ng[0]}), 64'd0);
    exp_q.delete();
    acc_q.delete();
    stl_q.delete();
    seen = 0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 8; k++) begin
      drive(0, 1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
      cycle(0);
    end
    send(0, 64'd40, 64'd2, 1'b0, 1'b0);
    drain(0);
    check_last("post_rst", 64'd42, 4'b0000);

    // random sweep on every configuration
    for (int g = 0; g < NCFG; g++) begin
      n_acc = 0;
      pend = 0;
      ra = '0; rb = '0; rop = 1'b0; rcin = 1'b0;
      for (int c = 0; c < 8000 && n_acc < 1000; c++) begin
        if (!pend && $urandom_range(0, 3) != 0) begin
          pend = 1;
          case ($urandom_range(0, 7))
            0:       ra = '1;
            1:       ra = '0;
            default: ra = {$urandom, $urandom};
          endcase
          case ($urandom_range(0, 7))
            0:       rb = '1;
            1:       rb = '0;
            default: rb = {$urandom, $urandom};
          endcase
          rop  = 1'($urandom_range(0, 1));
          rcin = 1'($urandom_range(0, 1));
        end
        drive(g, pend, ra, rb, rop, rcin, $urandom_range(0, 3) != 0);
        cycle(g);
        if (accepted) begin
          pend = 0;
          n_acc++;
        end
      end
      iv[g] = 1'b0;
      drain(g);
      chk("sweep_count", 64'(n_acc), 64'd1000);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
